// File: rtl/axi_stream_head_split_if.sv
// AXI-stream channel bundle shared by the input, head and body sides of
// the head splitter. The producer takes the master modport.
interface axi_stream_head_split_if #(
    parameter int DSIZE = 8,
    parameter int KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1
);
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tkeep,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axi_stream_head_split.sv
// Routes the first head_len beats of every input frame to the head stream
// (tlast forced on the last head beat) and the rest to the body stream.
// No data buffering: payload flows straight through, a small FSM and a
// beat counter choose which output gets the valid.
module axi_stream_head_split #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [LSIZE-1:0]        head_len,
    axi_stream_head_split_if.slave  s,
    axi_stream_head_split_if.master h,
    axi_stream_head_split_if.master b,
    output logic                    short_frame,
    output logic [15:0]             frame_cnt
);
    localparam int KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_HEAD  = 2'd1,
        S_BODY  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LSIZE-1:0] len_r;
    logic [LSIZE-1:0] len_nxt_s;
    logic [LSIZE-1:0] cnt_r;
    logic [LSIZE-1:0] cnt_nxt_s;
    logic [LSIZE-1:0] cnt_inc_s;
    logic             short_r;
    logic             short_nxt_s;
    logic [15:0]      frame_cnt_r;

    logic             route_head_s;
    logic             h_tlast_s;
    logic             s_tready_s;
    logic             acc_s;
    logic [DSIZE-1:0] data_s;
    logic [KSIZE-1:0] keep_s;

    assign cnt_inc_s = cnt_r + LSIZE'(1'b1);

    // Route decode: which output owns the current beat, and whether the
    // head copy of it must carry tlast.
    always_comb begin
        route_head_s = 1'b0;
        h_tlast_s    = s.tlast;
        case (state_r)
            S_START: begin
                route_head_s = (head_len != {LSIZE{1'b0}});
                h_tlast_s    = s.tlast | (head_len == LSIZE'(1'b1));
            end
            S_HEAD: begin
                route_head_s = 1'b1;
                h_tlast_s    = s.tlast | (cnt_inc_s == len_r);
            end
            S_BODY: begin
                route_head_s = 1'b0;
                h_tlast_s    = s.tlast;
            end
            default: begin
                route_head_s = 1'b0;
                h_tlast_s    = s.tlast;
            end
        endcase
    end

    // Only the selected output can stall the input; the other is ignored.
    assign s_tready_s = (route_head_s ? h.tready : b.tready) & ~rst;
    assign acc_s      = s.tvalid & s_tready_s;

    // Next-state logic: state, latched length and beat count move only on
    // an accepted beat, so the route is stable while a beat is pending.
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        cnt_nxt_s   = cnt_r;
        short_nxt_s = 1'b0;
        case (state_r)
            S_START: begin
                if (acc_s) begin
                    len_nxt_s = head_len;
                    cnt_nxt_s = LSIZE'(1'b1);
                    if (s.tlast) begin
                        state_nxt_s = S_START;
                        short_nxt_s = (head_len > LSIZE'(1'b1));
                    end else if (head_len <= LSIZE'(1'b1)) begin
                        state_nxt_s = S_BODY;
                    end else begin
                        state_nxt_s = S_HEAD;
                    end
                end else begin
                    state_nxt_s = S_START;
                end
            end
            S_HEAD: begin
                if (acc_s) begin
                    cnt_nxt_s = cnt_inc_s;
                    if (s.tlast) begin
                        state_nxt_s = S_START;
                        short_nxt_s = (cnt_inc_s < len_r);
                    end else if (cnt_inc_s == len_r) begin
                        state_nxt_s = S_BODY;
                    end else begin
                        state_nxt_s = S_HEAD;
                    end
                end else begin
                    state_nxt_s = S_HEAD;
                end
            end
            S_BODY: begin
                if (acc_s && s.tlast) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_BODY;
                end
            end
            default: begin
                state_nxt_s = S_START;
            end
        endcase
    end

    // State, counters and the registered short-frame pulse; reset abandons
    // any frame in progress.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= S_START;
            len_r       <= {LSIZE{1'b0}};
            cnt_r       <= {LSIZE{1'b0}};
            short_r     <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            len_r   <= len_nxt_s;
            cnt_r   <= cnt_nxt_s;
            short_r <= short_nxt_s;
            if (acc_s && s.tlast) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign data_s = s.tdata;
    assign keep_s = s.tkeep;

    assign s.tready = s_tready_s;

    assign h.tdata  = data_s;
    assign h.tkeep  = keep_s;
    assign h.tuser  = s.tuser;
    assign h.tlast  = h_tlast_s;
    assign h.tvalid = s.tvalid & route_head_s & ~rst;

    assign b.tdata  = data_s;
    assign b.tkeep  = keep_s;
    assign b.tuser  = s.tuser;
    assign b.tlast  = s.tlast;
    assign b.tvalid = s.tvalid & ~route_head_s & ~rst;

    assign short_frame = short_r;
    assign frame_cnt   = frame_cnt_r;
endmodule

// File: doc/axi_stream_head_split.md
Name: axi_stream_head_split

Overview:
- Upstream companion of the head/body/end stream combiner.
- Takes one AXI-stream packet input and routes the first head_len beats of every frame to a head output stream (tlast forced on the final head beat), and the remaining beats to a body output stream.
- Lets a datapath strip a protocol header, process or replace it, and feed both parts back into the combiner.
- Zero-latency routing (no data buffering); a small FSM plus a beat counter decide the route.

Parameters:
- DSIZE, 8, tdata width in bits.
- KSIZE, (DSIZE/8>0)?DSIZE/8:1, tkeep width; derived, not overridden.
- LSIZE, 16, width of head_len and the beat counter.

Ports:
- clock  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- head_len  in  LSIZE  number of head beats per frame; sampled only on the first beat of each frame.
- s_tdata  in  DSIZE  input stream data.
- s_tkeep  in  KSIZE  input stream keep.
- s_tuser  in  1  input stream user.
- s_tlast  in  1  input end of frame.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- h_tdata / h_tkeep / h_tuser  out  DSIZE / KSIZE / 1  head stream payload, copied from s_*.
- h_tlast  out  1  head end of frame.
- h_tvalid  out  1  head valid.
- h_tready  in  1  head ready.
- b_tdata / b_tkeep / b_tuser  out  DSIZE / KSIZE / 1  body stream payload, copied from s_*.
- b_tlast  out  1  body end of frame; equals s_tlast.
- b_tvalid  out  1  body valid.
- b_tready  in  1  body ready.
- short_frame  out  1  one-cycle pulse: frame ended before head_len beats.
- frame_cnt  out  16  count of completed input frames; wraps at 65535 to 0.

Behaviour:
- Beat accept (acc) = s_tvalid & s_tready.
- Routing:
  - route_head = 1 selects head, else body.
  - h_tvalid = s_tvalid & route_head & ~rst.
  - b_tvalid = s_tvalid & ~route_head & ~rst.
  - s_tready = (route_head ? h_tready : b_tready) & ~rst.
  - Payload is driven combinationally to both outputs; only valid is gated.
- FSM states S_START, S_HEAD, S_BODY. Registers: len_q (LSIZE), cnt (LSIZE).
- S_START: route_head = (head_len != 0). On acc:
  - len_q <= head_len; cnt <= 1.
  - If s_tlast: stay in S_START. Raise short_frame if head_len > 1.
  - Else if head_len <= 1: go to S_BODY.
  - Else: go to S_HEAD.
- S_HEAD: route_head = 1. On acc: cnt <= cnt+1.
  - If s_tlast: go to S_START. Raise short_frame if cnt+1 < len_q.
  - Else if cnt+1 == len_q: go to S_BODY.
- S_BODY: route_head = 0. On acc with s_tlast: go to S_START.
- h_tlast = s_tlast OR (the beat is head beat number len_q). In S_START that means head_len == 1; in S_HEAD it means cnt+1 == len_q.
- Exactly head_len beats in a frame: head frame carries tlast on its final beat; no body frame; no short_frame.
- head_len == 0: whole frame goes to body; head emits nothing.
- A change on head_len mid-frame has no effect; only the S_START sample is used.
- frame_cnt increments on every acc with s_tlast, whatever the state.
- Reset values: state S_START, len_q 0, cnt 0, short_frame 0, frame_cnt 0. All valids and s_tready are 0 while rst is high.
- Reset mid-frame abandons the frame. The next beat after reset release is treated as a first beat.
- Backpressure: a stall on the unselected output never blocks the input. The route does not change while a beat is pending unaccepted, because state only moves on acc.
- short_frame is registered: it is high for the cycle after the terminating acc.

Test Plan:
- head_len=3, 8-beat frame D0..D7, both readies 1 -> head gets D0..D2 with tlast on D2; body gets D3..D7 with tlast on D7; frame_cnt=1.
- head_len=4, 2-beat frame -> head gets D0,D1 with tlast on D1; body idle; short_frame pulses once.
- head_len=0, then 1, on 5-beat frames -> first frame: all 5 beats to body. Second: D0 to head with tlast, D1..D4 to body.
- head_len=2, b_tready held 0 for 10 cycles at the body boundary -> s_tready=0 and no beat is lost. head_len changed to 7 mid-frame has no effect. h_tready toggling is honoured.
- Assert rst during beat 2 of a head_len=3 frame, then send a fresh 4-beat frame -> fresh D0..D2 go to head and D3 to body. No short_frame; outputs idle during rst.
- 65536 single-beat frames -> frame_cnt wraps to 0.
